// File: rtl/clk_rst_sequencer.sv
// PLL supervisor and reset sequencer: pulses the PLL reset, filters LOCKED,
// then releases the downstream domain resets one at a time in index order.
module clk_rst_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 64,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int STAGGER_CYCLES = 32,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk_in1,
    input  logic                   reset,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   fail,
    output logic [7:0]             lock_lost_count
);

    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STAGGER_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int DW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [PW-1:0] PRST_LAST  = PW'(PLL_RST_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAG_LAST  = SW'(STAGGER_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
    localparam logic [DW-1:0] DOM_LAST   = DW'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            prst_q, prst_d;
    logic [FW-1:0]            filt_q, filt_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [SW-1:0]            stag_q, stag_d;
    logic [DW-1:0]            dom_q, dom_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic [7:0]               lost_q, lost_d;
    logic                     sync1_q, lock_s_q;

    logic                     pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0]   rst_out_q, rst_out_d;
    logic                     ready_q, ready_d;
    logic                     fail_q, fail_d;

    // State register. Outputs are registered from next-state values so they
    // change on the same edge as the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q   <= ST_PLL_RST;
            prst_q    <= '0;
            filt_q    <= '0;
            tmo_q     <= '0;
            stag_q    <= '0;
            dom_q     <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prst_q    <= prst_d;
            filt_q    <= filt_d;
            tmo_q     <= tmo_d;
            stag_q    <= stag_d;
            dom_q     <= dom_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            sync1_q   <= pll_locked;
            lock_s_q  <= sync1_q;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state logic. Per-state counters restart at zero on every transition.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        prst_d  = '0;
        filt_d  = '0;
        tmo_d   = '0;
        stag_d  = '0;
        dom_d   = '0;
        retry_d = retry_q;
        lost_d  = lost_q;

        unique case (state_q)
            ST_PLL_RST: begin
                if (prst_q == PRST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    prst_d = prst_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                // Filter completion takes priority over a coincident timeout.
                if (lock_s_q && (filt_q == FILT_LAST)) begin
                    state_d = ST_RELEASE;
                    retry_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    tmo_d  = tmo_q + 1'b1;
                    filt_d = lock_s_q ? (filt_q + 1'b1) : '0;
                end
            end

            ST_RELEASE: begin
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                    lost_d  = (lost_q == 8'hFF) ? lost_q : (lost_q + 8'd1);
                end else if (stag_q == STAG_LAST) begin
                    if (dom_q == DOM_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        dom_d = dom_q + 1'b1;
                    end
                end else begin
                    stag_d = stag_q + 1'b1;
                    dom_d  = dom_q;
                end
            end

            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                    lost_d  = (lost_q == 8'hFF) ? lost_q : (lost_q + 8'd1);
                end
            end

            ST_FAIL: begin
                state_d = ST_FAIL;
            end

            default: begin
                state_d = ST_FAIL;
            end
        endcase
    end

    // Output logic: domains up to and including dom_d are released in RELEASE.
    always_comb begin
        pll_rst_d = (state_d == ST_PLL_RST);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
        rst_out_d = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (state_d == ST_RUN) begin
                rst_out_d[i] = 1'b0;
            end else if (state_d == ST_RELEASE) begin
                rst_out_d[i] = (DW'(i) > dom_d);
            end
        end
    end

    assign pll_rst         = pll_rst_q;
    assign rst_out         = rst_out_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign lock_lost_count = lost_q;

    a_ready_released : assert property (@(posedge clk_in1) disable iff (reset)
        ready_q |-> (rst_out_q == '0));
    a_fail_held : assert property (@(posedge clk_in1) disable iff (reset)
        fail_q |-> ((rst_out_q == '1) && !pll_rst_q));

endmodule
